// File: rtl/bus_pkg.sv
// Shared definitions for the client-bus responder.
// Holds FSM encoding, wr_ni polarity constants and address-window check.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic BUS_RD = 1'b1;
    localparam logic BUS_WR = 1'b0;

    // Operands are zero-extended address-width values, so the
    // compare stays unsigned.
    function automatic logic in_space(
        input logic [31:0] addr,
        input logic [31:0] lo,
        input logic [31:0] hi
    );
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/server_regfile.sv
// Storage words behind the bus responder.
// Ports: clk, reset (async, high, clears storage and rdata),
//   we/idx/wdata synchronous write, re loads rdata = mem[idx].
module server_regfile #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4,
    localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic                  re,
    input  logic [IDX_W-1:0]      idx,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[idx] <= wdata;
            end
            // rdata is held between reads.
            if (re) begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/bus_server.sv
// Bus responder owning an address window with programmable wait states.
// Ports: clk, reset (async, high); address, rq, wr_ni (1=read),
//   dataW in; ack (one-cycle pulse), dataR (registered), busy out.
// Option BUS_SERVER_ACCESS_CNT_EN adds rd_count/wr_count outputs.
module bus_server
    import bus_pkg::*;
#(
    parameter int DATA_WIDTH           = 8,
    parameter int ADDR_WIDTH           = 4,
    parameter int ADDR_SPACE_BEGINNING = 0,
    parameter int ADDR_SPACE_END       = 3,
    parameter int WAIT_CYCLES          = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  rq,
    input  logic                  wr_ni,
    input  logic [DATA_WIDTH-1:0] dataW,
    output logic                  ack,
    output logic [DATA_WIDTH-1:0] dataR,
    output logic                  busy
`ifdef BUS_SERVER_ACCESS_CNT_EN
    ,
    output logic [15:0]           rd_count,
    output logic [15:0]           wr_count
`endif
);

    localparam int DEPTH =
        ADDR_SPACE_END - ADDR_SPACE_BEGINNING + 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] CNT_LOAD =
        4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t                state;
    logic [3:0]            cnt;
    logic [IDX_W-1:0]      req_idx;
    logic                  req_wr_ni;
    logic [DATA_WIDTH-1:0] req_data;

    logic                  hit;
    logic [IDX_W-1:0]      live_idx;
    logic                  go_ack;
    logic [IDX_W-1:0]      cur_idx;
    logic                  cur_wr_ni;
    logic [DATA_WIDTH-1:0] cur_data;
    logic                  we;
    logic                  re;

    assign hit = rq && in_space(32'(address),
                                32'(ADDR_SPACE_BEGINNING),
                                32'(ADDR_SPACE_END));

    assign live_idx = IDX_W'(address
                      - ADDR_WIDTH'(ADDR_SPACE_BEGINNING));

    // Commit happens on the edge entering ACK. With zero wait
    // states that is the accept edge, so the live request is used.
    always_comb begin
        go_ack    = 1'b0;
        cur_idx   = req_idx;
        cur_wr_ni = req_wr_ni;
        cur_data  = req_data;
        if (state == IDLE) begin
            go_ack    = hit && (WAIT_CYCLES == 0);
            cur_idx   = live_idx;
            cur_wr_ni = wr_ni;
            cur_data  = dataW;
        end else if (state == WAIT) begin
            go_ack = (cnt == 4'd0);
        end
        we = go_ack && (cur_wr_ni == BUS_WR);
        re = go_ack && (cur_wr_ni == BUS_RD);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            req_idx   <= '0;
            req_wr_ni <= BUS_RD;
            req_data  <= '0;
            ack       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    ack <= 1'b0;
                    if (hit) begin
                        req_idx   <= live_idx;
                        req_wr_ni <= wr_ni;
                        req_data  <= dataW;
                        busy      <= 1'b1;
                        if (WAIT_CYCLES > 0) begin
                            state <= WAIT;
                            cnt   <= CNT_LOAD;
                        end else begin
                            state <= ACK;
                            ack   <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= ACK;
                        ack   <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ACK: begin
                    // The request is not sampled here, so a
                    // lingering rq cannot be accepted twice.
                    state <= IDLE;
                    ack   <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    ack   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    server_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .re    (re),
        .idx   (cur_idx),
        .wdata (cur_data),
        .rdata (dataR)
    );

`ifdef BUS_SERVER_ACCESS_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_count <= 16'd0;
            wr_count <= 16'd0;
        end else begin
            if (re) begin
                rd_count <= rd_count + 16'd1;
            end
            if (we) begin
                wr_count <= wr_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_bus_server.sv
// Self-checking bench for bus_server with 0, 1 and 3 wait states.
// Randomised transactions are checked against a memory-array model.
module tb_bus_server;
    import bus_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] address;
    logic       wr_ni;
    logic [7:0] dataW;
    logic [2:0] rq_v;
    logic [2:0] ack_v;
    logic [2:0] busy_v;
    logic [7:0] dr [3];
`ifdef BUS_SERVER_ACCESS_CNT_EN
    logic [15:0] rdc [3];
    logic [15:0] wrc [3];
`endif

    int compared   = 0;
    int mismatched = 0;
    logic [7:0] mem [3][4];

    always #5 clk = ~clk;

    bus_server #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .address(address),
        .rq(rq_v[0]), .wr_ni(wr_ni), .dataW(dataW),
        .ack(ack_v[0]), .dataR(dr[0]), .busy(busy_v[0])
`ifdef BUS_SERVER_ACCESS_CNT_EN
        , .rd_count(rdc[0]), .wr_count(wrc[0])
`endif
    );

    bus_server #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .address(address),
        .rq(rq_v[1]), .wr_ni(wr_ni), .dataW(dataW),
        .ack(ack_v[1]), .dataR(dr[1]), .busy(busy_v[1])
`ifdef BUS_SERVER_ACCESS_CNT_EN
        , .rd_count(rdc[1]), .wr_count(wrc[1])
`endif
    );

    bus_server #(.WAIT_CYCLES(3)) dut3 (
        .clk(clk), .reset(reset), .address(address),
        .rq(rq_v[2]), .wr_ni(wr_ni), .dataW(dataW),
        .ack(ack_v[2]), .dataR(dr[2]), .busy(busy_v[2])
`ifdef BUS_SERVER_ACCESS_CNT_EN
        , .rd_count(rdc[2]), .wr_count(wrc[2])
`endif
    );

    function automatic int wc(input int d);
        return (d == 0) ? 0 : (d == 1) ? 1 : 3;
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 3; d++)
            for (int i = 0; i < 4; i++)
                mem[d][i] = 8'h00;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        rq_v  = 3'b000;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_model();
    endtask

    // One transaction on server d; checks busy, latency and read data.
    task automatic run_txn(input int d, input bit wr,
                           input logic [3:0] a,
                           input logic [7:0] data,
                           input bit drop);
        int w;
        bit seen;
        w    = wc(d);
        seen = 1'b0;
        @(negedge clk);
        address = a;
        wr_ni   = wr ? BUS_WR : BUS_RD;
        dataW   = data;
        rq_v[d] = 1'b1;
        @(posedge clk);
        if (a > 4'd3) begin
            repeat (w + 3) begin
                @(negedge clk);
                compared++;
                if (ack_v[d] !== 1'b0 || busy_v[d] !== 1'b0) begin
                    mismatched++;
                    $display("FAIL out_of_range d=%0d a=%0d ack=%b busy=%b want 0/0",
                             d, a, ack_v[d], busy_v[d]);
                end
            end
            rq_v[d] = 1'b0;
            return;
        end
        for (int lat = 0; lat <= w + 2 && !seen; lat++) begin
            @(negedge clk);
            if (drop) begin
                rq_v[d] = 1'b0;
                address = 4'($urandom);
                dataW   = 8'($urandom);
                wr_ni   = 1'($urandom);
            end
            compared++;
            if (busy_v[d] !== 1'b1) begin
                mismatched++;
                $display("FAIL busy d=%0d lat=%0d got %b want 1",
                         d, lat, busy_v[d]);
            end
            if (ack_v[d] === 1'b1) begin
                seen = 1'b1;
                compared++;
                if (lat != w) begin
                    mismatched++;
                    $display("FAIL latency d=%0d got %0d want %0d",
                             d, lat, w);
                end
                if (wr) begin
                    mem[d][a] = data;
                end else begin
                    compared++;
                    if (dr[d] !== mem[d][a]) begin
                        mismatched++;
                        $display("FAIL read_data d=%0d a=%0d got %h want %h",
                                 d, a, dr[d], mem[d][a]);
                    end
                end
                rq_v[d] = 1'b0;
            end
        end
        if (!seen) begin
            compared++;
            mismatched++;
            $display("FAIL ack_timeout d=%0d a=%0d got none want ack",
                     d, a);
        end
        rq_v[d] = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        clear_model();
        repeat (10) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                compared++;
                if (ack_v[d] !== 1'b0 || busy_v[d] !== 1'b0 ||
                    dr[d] !== 8'h00) begin
                    mismatched++;
                    $display("FAIL reset_state d=%0d ack=%b busy=%b dataR=%h want 0/0/00",
                             d, ack_v[d], busy_v[d], dr[d]);
                end
`ifdef BUS_SERVER_ACCESS_CNT_EN
                compared++;
                if (rdc[d] !== 16'd0 || wrc[d] !== 16'd0) begin
                    mismatched++;
                    $display("FAIL reset_counts d=%0d rd=%0d wr=%0d want 0/0",
                             d, rdc[d], wrc[d]);
                end
`endif
            end
        end
    endtask

    task automatic test_write_read();
        run_txn(1, 1'b1, 4'd2, 8'hA5, 1'b0);
        run_txn(1, 1'b0, 4'd2, 8'h00, 1'b0);
        repeat (4) begin
            @(negedge clk);
            compared++;
            if (dr[1] !== mem[1][2]) begin
                mismatched++;
                $display("FAIL dataR_hold got %h want %h",
                         dr[1], mem[1][2]);
            end
        end
        run_txn(1, 1'b1, 4'd3, 8'h5A, 1'b0);
        @(negedge clk);
        compared++;
        if (dr[1] !== mem[1][2]) begin
            mismatched++;
            $display("FAIL write_keeps_dataR got %h want %h",
                     dr[1], mem[1][2]);
        end
        run_txn(1, 1'b0, 4'd3, 8'h00, 1'b0);
    endtask

    task automatic test_out_of_range();
        @(negedge clk);
        address = 4'd7;
        wr_ni   = BUS_WR;
        dataW   = 8'hEE;
        rq_v[1] = 1'b1;
        repeat (8) begin
            @(negedge clk);
            compared++;
            if (ack_v[1] !== 1'b0 || busy_v[1] !== 1'b0) begin
                mismatched++;
                $display("FAIL addr7_ignored ack=%b busy=%b want 0/0",
                         ack_v[1], busy_v[1]);
            end
        end
        rq_v[1] = 1'b0;
        for (int i = 0; i < 4; i++)
            run_txn(1, 1'b0, 4'(i), 8'h00, 1'b0);
    endtask

    task automatic test_rq_drop();
        run_txn(2, 1'b1, 4'd1, 8'h3C, 1'b1);
        run_txn(2, 1'b0, 4'd1, 8'h00, 1'b0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        address = 4'd0;
        wr_ni   = BUS_WR;
        dataW   = 8'hFF;
        rq_v[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        compared++;
        if (busy_v[2] !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_busy got %b want 1", busy_v[2]);
        end
        reset   = 1'b1;
        rq_v    = 3'b000;
        #1;
        compared++;
        if (ack_v[2] !== 1'b0 || busy_v[2] !== 1'b0) begin
            mismatched++;
            $display("FAIL async_reset ack=%b busy=%b want 0/0",
                     ack_v[2], busy_v[2]);
        end
        clear_model();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            compared++;
            if (ack_v[2] !== 1'b0) begin
                mismatched++;
                $display("FAIL dropped_write_ack got %b want 0",
                         ack_v[2]);
            end
        end
        run_txn(2, 1'b0, 4'd0, 8'h00, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            int d;
            logic [3:0] a;
            d = int'($urandom_range(0, 2));
            if ($urandom_range(0, 4) == 0)
                a = 4'($urandom_range(4, 15));
            else
                a = 4'($urandom_range(0, 3));
            run_txn(d, 1'($urandom), a, 8'($urandom),
                    ($urandom_range(0, 3) == 0));
        end
    endtask

    task automatic test_back_to_back();
        bit         op_wr [5];
        logic [3:0] op_a  [5];
        logic [7:0] op_d  [5];
        int idx, last, acks, wr_exp, rd_exp;
        op_wr = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        op_a  = '{4'd0, 4'd1, 4'd2, 4'd1, 4'd2};
        for (int i = 0; i < 5; i++)
            op_d[i] = 8'($urandom);
        idx = 0; last = -1; acks = 0;
        wr_exp = 0; rd_exp = 0;
        apply_reset();
        @(negedge clk);
        address = op_a[0];
        wr_ni   = BUS_WR;
        dataW   = op_d[0];
        rq_v[1] = 1'b1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (ack_v[1] === 1'b1) begin
                acks++;
                if (idx < 5) begin
                    if (last >= 0) begin
                        compared++;
                        if (cyc - last != wc(1) + 2) begin
                            mismatched++;
                            $display("FAIL b2b_gap got %0d want %0d",
                                     cyc - last, wc(1) + 2);
                        end
                    end
                    if (op_wr[idx]) begin
                        mem[1][op_a[idx]] = op_d[idx];
                        wr_exp++;
                    end else begin
                        rd_exp++;
                        compared++;
                        if (dr[1] !== mem[1][op_a[idx]]) begin
                            mismatched++;
                            $display("FAIL b2b_read a=%0d got %h want %h",
                                     op_a[idx], dr[1],
                                     mem[1][op_a[idx]]);
                        end
                    end
                    idx++;
                    if (idx < 5) begin
                        address = op_a[idx];
                        wr_ni   = op_wr[idx] ? BUS_WR : BUS_RD;
                        dataW   = op_d[idx];
                    end else begin
                        rq_v[1] = 1'b0;
                    end
                end
                last = cyc;
            end
        end
        rq_v[1] = 1'b0;
        compared++;
        if (acks != 5) begin
            mismatched++;
            $display("FAIL b2b_ack_count got %0d want 5", acks);
        end
`ifdef BUS_SERVER_ACCESS_CNT_EN
        compared++;
        if (wrc[1] !== 16'(wr_exp) || rdc[1] !== 16'(rd_exp)) begin
            mismatched++;
            $display("FAIL access_counts wr=%0d rd=%0d want %0d/%0d",
                     wrc[1], rdc[1], wr_exp, rd_exp);
        end
`endif
    endtask

    initial begin
        reset   = 1'b1;
        rq_v    = 3'b000;
        address = 4'd0;
        wr_ni   = BUS_RD;
        dataW   = 8'h00;
        test_reset();
        test_write_read();
        test_out_of_range();
        test_rq_drop();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
